// File: rtl/fpu_ftoi_pipe_if.sv
// Issue/result bundle between an FPU issue stage and the float -> integer converter.
// The master issues ops and collects results; the converter is the slave.
interface fpu_ftoi_pipe_if #(
   parameter int INT_WIDTH  = 32,
   parameter int DEST_WIDTH = 5
);
   logic                  start;
   logic [31:0]           in_float;
   logic [DEST_WIDTH-1:0] in_dest;
   logic                  in_unsigned;
   logic [1:0]            in_round;
   logic                  f2i_valid;
   logic [INT_WIDTH-1:0]  f2i_integer;
   logic [DEST_WIDTH-1:0] f2i_dest;
   logic                  f2i_invalid;
   logic                  f2i_inexact;

   modport master (
      output start, in_float, in_dest, in_unsigned, in_round,
      input  f2i_valid, f2i_integer, f2i_dest, f2i_invalid, f2i_inexact
   );

   modport slave (
      input  start, in_float, in_dest, in_unsigned, in_round,
      output f2i_valid, f2i_integer, f2i_dest, f2i_invalid, f2i_inexact
   );
endinterface

// File: rtl/fpu_ftoi_pipe.sv
// Pipelined single-precision float -> INT_WIDTH integer converter, fixed latency STAGES.
// Define FPU_FTOI_ROUND_EN to honour in_round; otherwise conversion always truncates (RTZ).
module fpu_ftoi_pipe #(
   parameter int INT_WIDTH  = 32,
   parameter int DEST_WIDTH = 5,
   parameter int STAGES     = 2
) (
   input logic            clock,
   input logic            reset,
   fpu_ftoi_pipe_if.slave io
);
   localparam int IW = INT_WIDTH + 2;   // integer bits held before the range check
   localparam int AW = IW + 23;         // aligned magnitude with 23 fraction bits
   localparam int MW = IW + 1;          // rounded magnitude

   localparam logic [MW-1:0] LIM_U  = (MW'(1) << INT_WIDTH) - MW'(1);
   localparam logic [MW-1:0] LIM_SP = (MW'(1) << (INT_WIDTH - 1)) - MW'(1);
   localparam logic [MW-1:0] LIM_SN = MW'(1) << (INT_WIDTH - 1);
   localparam logic [INT_WIDTH-1:0] SMAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
   localparam logic [INT_WIDTH-1:0] SMIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

   typedef struct packed {
      logic [DEST_WIDTH-1:0] dest;
      logic [INT_WIDTH-1:0]  value;
      logic                  invalid;
      logic                  inexact;
   } res_t;

   logic          sign;
   logic [7:0]    exp_f;
   logic [22:0]   mant;
   int            e_unb;
   logic          is_nan;
   logic          ovf;
   logic [AW-1:0] acc;
   logic [IW-1:0] int_part;
   logic          guard;
   logic          sticky;
   logic [MW-1:0] mag_r;
`ifdef FPU_FTOI_ROUND_EN
   logic          inc;
`endif
   res_t          conv;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      sign     = io.in_float[31];
      exp_f    = io.in_float[30:23];
      mant     = io.in_float[22:0];
      e_unb    = int'(exp_f) - 127;
      is_nan   = (exp_f == 8'hFF) && (mant != '0);
      ovf      = (exp_f == 8'hFF) || (e_unb > INT_WIDTH + 1);
      acc      = '0;
      int_part = '0;
      guard    = 1'b0;
      sticky   = 1'b0;

      // Magnitudes below one only contribute guard/sticky; larger ones are aligned.
      if (exp_f == 8'h00) begin
         sticky = |mant;
      end else if (e_unb < -1) begin
         sticky = 1'b1;
      end else if (e_unb == -1) begin
         guard  = 1'b1;
         sticky = |mant;
      end else if (!ovf) begin
         acc      = AW'({1'b1, mant}) << e_unb;
         int_part = acc[AW-1:23];
         guard    = acc[22];
         sticky   = |acc[21:0];
      end

`ifdef FPU_FTOI_ROUND_EN
      unique case (io.in_round)
         2'd0:    inc = guard & (sticky | acc[23]);
         2'd1:    inc = 1'b0;
         2'd2:    inc = sign & (guard | sticky);
         default: inc = ~sign & (guard | sticky);
      endcase
      mag_r = MW'(int_part) + MW'(inc);
`else
      mag_r = MW'(int_part);
`endif

      conv         = '0;
      conv.dest    = io.in_dest;
      if (is_nan) begin
         conv.value   = io.in_unsigned ? '1 : SMAX;
         conv.invalid = 1'b1;
      end else if (io.in_unsigned) begin
         if (sign) begin
            // Negative values are legal only when they round to zero.
            if (!ovf && (mag_r == '0)) conv.inexact = guard | sticky;
            else                        conv.invalid = 1'b1;
         end else if (ovf || (mag_r > LIM_U)) begin
            conv.value   = '1;
            conv.invalid = 1'b1;
         end else begin
            conv.value   = mag_r[INT_WIDTH-1:0];
            conv.inexact = guard | sticky;
         end
      end else if (sign) begin
         if (ovf || (mag_r > LIM_SN)) begin
            conv.value   = SMIN;
            conv.invalid = 1'b1;
         end else begin
            conv.value   = ~mag_r[INT_WIDTH-1:0] + INT_WIDTH'(1);
            conv.inexact = guard | sticky;
         end
      end else if (ovf || (mag_r > LIM_SP)) begin
         conv.value   = SMAX;
         conv.invalid = 1'b1;
      end else begin
         conv.value   = mag_r[INT_WIDTH-1:0];
         conv.inexact = guard | sticky;
      end
   end

   res_t              pipe_q [STAGES];
   logic [STAGES-1:0] vld_q;

   // NOTE: payload registers are reset along with the valids so outputs read zero after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
      end else begin
         vld_q[0] <= io.start;
         if (io.start) pipe_q[0] <= conv;
         for (int i = 1; i < STAGES; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign io.f2i_valid   = vld_q[STAGES-1];
   assign io.f2i_integer = pipe_q[STAGES-1].value;
   assign io.f2i_dest    = pipe_q[STAGES-1].dest;
   assign io.f2i_invalid = pipe_q[STAGES-1].invalid;
   assign io.f2i_inexact = pipe_q[STAGES-1].inexact;
endmodule

// File: tb/tb_fpu_ftoi_pipe.sv
// Scoreboarded bench for fpu_ftoi_pipe: directed conversions on STAGES=2, latency/order on 1 and 3.
// Expectations follow FPU_FTOI_ROUND_EN when it is defined for the build.
module tb_fpu_ftoi_pipe;
   localparam int W  = 32;
   localparam int DW = 5;
`ifdef FPU_FTOI_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif
   localparam logic [1:0] RNE = 2'd0, RTZ = 2'd1, RDN = 2'd2, RUP = 2'd3;

   typedef struct {
      int            cyc;
      logic [DW-1:0] dest;
      logic [W-1:0]  value;
      logic          invalid;
      logic          inexact;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   in_float = '0;
   logic [DW-1:0] in_dest = '0;
   logic          in_unsigned = 1'b0;
   logic [1:0]    in_round = RNE;
   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;
   exp_t          q1[$], q2[$], q3[$];
   exp_t          e1, e2, e3;

   fpu_ftoi_pipe_if #(.INT_WIDTH(W), .DEST_WIDTH(DW)) bus1 ();
   fpu_ftoi_pipe_if #(.INT_WIDTH(W), .DEST_WIDTH(DW)) bus2 ();
   fpu_ftoi_pipe_if #(.INT_WIDTH(W), .DEST_WIDTH(DW)) bus3 ();

   assign bus1.start = start;  assign bus1.in_float = in_float;  assign bus1.in_dest = in_dest;
   assign bus1.in_unsigned = in_unsigned;  assign bus1.in_round = in_round;
   assign bus2.start = start;  assign bus2.in_float = in_float;  assign bus2.in_dest = in_dest;
   assign bus2.in_unsigned = in_unsigned;  assign bus2.in_round = in_round;
   assign bus3.start = start;  assign bus3.in_float = in_float;  assign bus3.in_dest = in_dest;
   assign bus3.in_unsigned = in_unsigned;  assign bus3.in_round = in_round;

   fpu_ftoi_pipe #(.INT_WIDTH(W), .DEST_WIDTH(DW), .STAGES(1)) dut1 (.clock(clock), .reset(reset), .io(bus1));
   fpu_ftoi_pipe #(.INT_WIDTH(W), .DEST_WIDTH(DW), .STAGES(2)) dut2 (.clock(clock), .reset(reset), .io(bus2));
   fpu_ftoi_pipe #(.INT_WIDTH(W), .DEST_WIDTH(DW), .STAGES(3)) dut3 (.clock(clock), .reset(reset), .io(bus3));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic score(input string p, input int st, input exp_t e, input logic [DW-1:0] d,
                        input logic [W-1:0] v, input logic inv, input logic inx);
      check({p, "_latency"}, 64'(cyc - e.cyc), 64'(st));
      check({p, "_dest"}, 64'(d), 64'(e.dest));
      check({p, "_integer"}, 64'(v), 64'(e.value));
      check({p, "_invalid"}, 64'(inv), 64'(e.invalid));
      check({p, "_inexact"}, 64'(inx), 64'(e.inexact));
   endtask

   // Each monitor pops the oldest expectation, so order and latency are checked together.
   always @(negedge clock) begin
      if (bus1.f2i_valid !== 1'b0) begin
         if (q1.size() == 0) check("s1_unexpected_valid", 64'(bus1.f2i_valid), 64'd0);
         else begin
            e1 = q1.pop_front();
            score("s1", 1, e1, bus1.f2i_dest, bus1.f2i_integer, bus1.f2i_invalid, bus1.f2i_inexact);
         end
      end
      if (bus2.f2i_valid !== 1'b0) begin
         if (q2.size() == 0) check("s2_unexpected_valid", 64'(bus2.f2i_valid), 64'd0);
         else begin
            e2 = q2.pop_front();
            score("s2", 2, e2, bus2.f2i_dest, bus2.f2i_integer, bus2.f2i_invalid, bus2.f2i_inexact);
         end
      end
      if (bus3.f2i_valid !== 1'b0) begin
         if (q3.size() == 0) check("s3_unexpected_valid", 64'(bus3.f2i_valid), 64'd0);
         else begin
            e3 = q3.pop_front();
            score("s3", 3, e3, bus3.f2i_dest, bus3.f2i_integer, bus3.f2i_invalid, bus3.f2i_inexact);
         end
      end
   end

   task automatic issue(input logic [31:0] f, input logic [DW-1:0] d, input logic u, input logic [1:0] r,
                        input logic [W-1:0] v, input logic inv, input logic inx);
      exp_t e;
      @(posedge clock);
      #1;
      start = 1'b1;  in_float = f;  in_dest = d;  in_unsigned = u;  in_round = r;
      e.cyc = cyc;  e.dest = d;  e.value = v;  e.invalid = inv;  e.inexact = inx;
      q1.push_back(e);
      q2.push_back(e);
      q3.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         start = 1'b0;
      end
   endtask

   task automatic check_drained(input string p);
      check({p, "_q1_left"}, 64'(q1.size()), 64'd0);
      check({p, "_q2_left"}, 64'(q2.size()), 64'd0);
      check({p, "_q3_left"}, 64'(q3.size()), 64'd0);
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      check("rst_valid", 64'(bus2.f2i_valid), 64'd0);
      check("rst_integer", 64'(bus2.f2i_integer), 64'd0);
      check("rst_dest", 64'(bus2.f2i_dest), 64'd0);
      check("rst_invalid", 64'(bus2.f2i_invalid), 64'd0);
      check("rst_inexact", 64'(bus2.f2i_inexact), 64'd0);
      check("rst_valid_s1", 64'(bus1.f2i_valid), 64'd0);
      check("rst_valid_s3", 64'(bus3.f2i_valid), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // Directed conversions, issued back to back.
      issue(32'h40200000, 5'd10, 1'b0, RNE, 32'd2, 1'b0, 1'b1);
      issue(32'h40200000, 5'd11, 1'b0, RTZ, 32'd2, 1'b0, 1'b1);
      issue(32'h40200000, 5'd12, 1'b0, RDN, 32'd2, 1'b0, 1'b1);
      issue(32'h40200000, 5'd13, 1'b0, RUP, RND ? 32'd3 : 32'd2, 1'b0, 1'b1);
      issue(32'hC0200000, 5'd14, 1'b0, RDN, RND ? 32'hFFFFFFFD : 32'hFFFFFFFE, 1'b0, 1'b1);
      issue(32'h4F32D05E, 5'd15, 1'b0, RTZ, 32'h7FFFFFFF, 1'b1, 1'b0);
      issue(32'h4F32D05E, 5'd16, 1'b1, RTZ, 32'hB2D05E00, 1'b0, 1'b0);
      issue(32'h7FC00000, 5'd17, 1'b0, RNE, 32'h7FFFFFFF, 1'b1, 1'b0);
      issue(32'hFF800000, 5'd18, 1'b0, RNE, 32'h80000000, 1'b1, 1'b0);
      issue(32'hCF000000, 5'd19, 1'b0, RNE, 32'h80000000, 1'b0, 1'b0);
      issue(32'hBECCCCCD, 5'd20, 1'b1, RTZ, 32'h00000000, 1'b0, 1'b1);
      issue(32'hBF800000, 5'd21, 1'b1, RTZ, 32'h00000000, 1'b1, 1'b0);
      issue(32'h80000000, 5'd22, 1'b0, RNE, 32'h00000000, 1'b0, 1'b0);
      issue(32'h7F800000, 5'd23, 1'b1, RNE, 32'hFFFFFFFF, 1'b1, 1'b0);
      issue(32'hFF800000, 5'd24, 1'b1, RNE, 32'h00000000, 1'b1, 1'b0);
      issue(32'h3FC00000, 5'd25, 1'b0, RNE, RND ? 32'd2 : 32'd1, 1'b0, 1'b1);
      issue(32'h40600000, 5'd26, 1'b0, RNE, RND ? 32'd4 : 32'd3, 1'b0, 1'b1);
      issue(32'hCF000001, 5'd27, 1'b0, RTZ, 32'h80000000, 1'b1, 1'b0);
      issue(32'h4F7FFFFF, 5'd28, 1'b1, RTZ, 32'hFFFFFF00, 1'b0, 1'b0);
      issue(32'h4F800000, 5'd29, 1'b1, RTZ, 32'hFFFFFFFF, 1'b1, 1'b0);
      issue(32'hFFC00000, 5'd30, 1'b1, RTZ, 32'hFFFFFFFF, 1'b1, 1'b0);
      issue(32'h00000001, 5'd31, 1'b0, RUP, RND ? 32'd1 : 32'd0, 1'b0, 1'b1);
      issue(32'hBF000000, 5'd9, 1'b1, RDN, 32'd0, RND, !RND);
      idle(2);

      // Three consecutive starts, dest 1..3; the last one leaves its value on the outputs.
      issue(32'h41200000, 5'd1, 1'b0, RTZ, 32'd10, 1'b0, 1'b0);
      issue(32'hC1A00000, 5'd2, 1'b0, RTZ, 32'hFFFFFFEC, 1'b0, 1'b0);
      issue(32'h40200000, 5'd3, 1'b0, RTZ, 32'd2, 1'b0, 1'b1);
      idle(6);
      check_drained("run1");
      check("hold_integer", 64'(bus2.f2i_integer), 64'd2);
      check("hold_dest", 64'(bus2.f2i_dest), 64'd3);
      check("hold_inexact", 64'(bus2.f2i_inexact), 64'd1);

      // Reset one cycle after a start: the op must vanish and outputs clear immediately.
      issue(32'h42F60000, 5'd7, 1'b0, RTZ, 32'd123, 1'b0, 1'b0);
      idle(1);
      #1;
      reset = 1'b1;
      q1.delete();
      q2.delete();
      q3.delete();
      #1;
      check("arst_valid", 64'(bus2.f2i_valid), 64'd0);
      check("arst_integer", 64'(bus2.f2i_integer), 64'd0);
      check("arst_dest", 64'(bus2.f2i_dest), 64'd0);
      check("arst_inexact", 64'(bus2.f2i_inexact), 64'd0);
      check("arst_valid_s1", 64'(bus1.f2i_valid), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("post_rst_valid_s2", 64'(bus2.f2i_valid), 64'd0);
         check("post_rst_valid_s3", 64'(bus3.f2i_valid), 64'd0);
      end

      issue(32'h4B000001, 5'd4, 1'b0, RNE, 32'h00800001, 1'b0, 1'b0);
      idle(6);
      check_drained("run2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
